// File: rtl/inst_mem_loader.sv
// Instruction memory loaded from a byte stream, then serving registered word-indexed fetches.
// Bytes are packed into words by BIG_ENDIAN order and written sequentially from word 0.
module inst_mem_loader #(
    parameter int                   WORD_SIZE  = 32,
    parameter int                   DEPTH      = 256,
    parameter int                   ADDR_W     = 8,
    parameter bit                   BIG_ENDIAN = 1'b1,
    parameter logic [WORD_SIZE-1:0] NOP_WORD   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [7:0]           load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 load_done,
    output logic                 load_overflow,
    output logic [ADDR_W:0]      load_count,
    output logic                 busy,
    input  logic                 read_en,
    input  logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] instruction,
    output logic                 instruction_valid,
    output logic                 addr_fault
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   buf_q, buf_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic [DEPTH-1:0]       loaded_q, loaded_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
    logic                   ovf_chk_q, ovf_chk_d;
    logic                   we;
    logic [WORD_SIZE-1:0]   wdata;
    logic [WORD_SIZE-1:0]   mem [DEPTH];
    logic [WORD_SIZE-1:0]   instr_q;
    logic                   ivld_q;
    logic                   fault_q;

    function automatic logic [WORD_SIZE-1:0] place_byte(input logic [WORD_SIZE-1:0] w,
                                                        input logic [CNT_W-1:0]     pos,
                                                        input logic [7:0]           b);
        int sh;
        sh = BIG_ENDIAN ? (BYTES - 1 - int'(pos)) * 8 : int'(pos) * 8;
        return w | (WORD_SIZE'(b) << sh);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        count_d   = count_q;
        loaded_d  = loaded_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        ovf_chk_d = 1'b0;
        we        = 1'b0;
        wdata     = place_byte(buf_q, cnt_q, load_data);
        case (state_q)
            S_IDLE, S_RUN: begin
                // Bytes still offered right after a full-memory end mean the image was too big.
                if (state_q == S_RUN && ovf_chk_q && load_valid) ovf_d = 1'b1;
                if (load_start) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    buf_d    = '0;
                    count_d  = '0;
                    loaded_d = '0;
                    ovf_d    = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    if (cnt_q == CNT_W'(BYTES - 1) || load_last) begin
                        we                             = 1'b1;
                        loaded_d[count_q[ADDR_W-1:0]]  = 1'b1;
                        count_d                        = count_q + 1'b1;
                        cnt_d                          = '0;
                        buf_d                          = '0;
                        if (load_last) begin
                            state_d = S_RUN;
                            done_d  = 1'b1;
                        end else if (count_q == (ADDR_W+1)'(DEPTH - 1)) begin
                            state_d   = S_RUN;
                            done_d    = 1'b1;
                            ovf_chk_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        buf_d = wdata;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            count_q   <= '0;
            loaded_q  <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            ovf_chk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            count_q   <= count_d;
            loaded_q  <= loaded_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            ovf_chk_q <= ovf_chk_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (we) mem[count_q[ADDR_W-1:0]] <= wdata;
    end

    // Fetch stage: one-cycle registered read, pulse-per-request valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= '0;
            ivld_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ivld_q  <= 1'b0;
            fault_q <= 1'b0;
            if (state_q == S_RUN && read_en) begin
                ivld_q <= 1'b1;
                if (address >= WORD_SIZE'(DEPTH)) begin
                    instr_q <= NOP_WORD;
                    fault_q <= 1'b1;
                end else if (loaded_q[address[ADDR_W-1:0]]) begin
                    instr_q <= mem[address[ADDR_W-1:0]];
                end else begin
                    instr_q <= NOP_WORD;
                end
            end
        end
    end

    assign load_ready        = (state_q == S_LOAD);
    assign busy              = (state_q == S_LOAD);
    assign load_done         = done_q;
    assign load_overflow     = ovf_q;
    assign load_count        = count_q;
    assign instruction       = instr_q;
    assign instruction_valid = ivld_q;
    assign addr_fault        = fault_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: three instances (default, DEPTH=4, little-endian) share one stimulus stream.
module tb_inst_mem_loader;
    logic        clk = 1'b0;
    logic        rst, load_start, load_valid, load_last, read_en;
    logic [7:0]  load_data;
    logic [31:0] address;

    logic        a_ready, a_done, a_ovf, a_busy, a_ivld, a_fault;
    logic [8:0]  a_count;
    logic [31:0] a_instr;
    logic        b_ready, b_done, b_ovf, b_busy, b_ivld, b_fault;
    logic [2:0]  b_count;
    logic [31:0] b_instr;
    logic        c_ready, c_done, c_ovf, c_busy, c_ivld, c_fault;
    logic [8:0]  c_count;
    logic [31:0] c_instr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_mem_loader u_a (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(a_ready),
        .load_done(a_done), .load_overflow(a_ovf), .load_count(a_count), .busy(a_busy),
        .read_en(read_en), .address(address), .instruction(a_instr),
        .instruction_valid(a_ivld), .addr_fault(a_fault)
    );

    inst_mem_loader #(.DEPTH(4), .ADDR_W(2)) u_b (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(b_ready),
        .load_done(b_done), .load_overflow(b_ovf), .load_count(b_count), .busy(b_busy),
        .read_en(read_en), .address(address), .instruction(b_instr),
        .instruction_valid(b_ivld), .addr_fault(b_fault)
    );

    inst_mem_loader #(.BIG_ENDIAN(1'b0)) u_c (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(c_ready),
        .load_done(c_done), .load_overflow(c_ovf), .load_count(c_count), .busy(c_busy),
        .read_en(read_en), .address(address), .instruction(c_instr),
        .instruction_valid(c_ivld), .addr_fault(c_fault)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_data  = b;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        read_en = 1'b1;
        address = a;
        step();
        read_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  img1 [8] = '{8'h00, 8'h20, 8'h08, 8'h20, 8'h8C, 8'h09, 8'h00, 8'h04};
        logic [7:0]  img2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        logic [7:0]  img3 [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        logic [31:0] exp_b [4] = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};

        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = 8'h00; read_en = 1'b0; address = '0;
        step(); step();
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_done", a_done, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_count", a_count, 0);
        chk("rst_instr", a_instr, 0);
        chk("rst_ivld", a_ivld, 0);
        chk("rst_fault", a_fault, 0);
        rst = 1'b0;

        // Big-endian 8-byte image.
        start_load();
        chk("t1_busy", a_busy, 1);
        chk("t1_ready", a_ready, 1);
        for (int i = 0; i < 8; i++) send_byte(img1[i], i == 7);
        chk("t1_done", a_done, 1);
        chk("t1_count", a_count, 2);
        chk("t1_run_busy", a_busy, 0);
        step();
        chk("t1_done_pulse", a_done, 0);

        fetch(1);
        chk("t2_instr1", a_instr, 32'h8C090004);
        chk("t2_ivld", a_ivld, 1);
        chk("t2_fault", a_fault, 0);
        read_en = 1'b1; address = 0;
        step();
        chk("t2_b2b_0", a_instr, 32'h00200820);
        chk("t2_b2b_v0", a_ivld, 1);
        address = 1;
        step();
        chk("t2_b2b_1", a_instr, 32'h8C090004);
        chk("t2_b2b_v1", a_ivld, 1);
        read_en = 1'b0;
        step();
        chk("t2_ivld_off", a_ivld, 0);
        chk("t2_instr_hold", a_instr, 32'h8C090004);

        // Partial final word is zero padded.
        start_load();
        for (int i = 0; i < 6; i++) send_byte(img2[i], i == 5);
        chk("t3_done", a_done, 1);
        chk("t3_count", a_count, 2);
        fetch(0);
        chk("t3_word0", a_instr, 32'hAABBCCDD);
        fetch(1);
        chk("t3_word1", a_instr, 32'h11220000);
        fetch(5);
        chk("t3_unl_instr", a_instr, 32'h0);
        chk("t3_unl_ivld", a_ivld, 1);
        chk("t3_unl_fault", a_fault, 0);
        fetch(1);
        fetch(300);
        chk("t3_oor_instr", a_instr, 32'h0);
        chk("t3_oor_fault", a_fault, 1);
        chk("t3_oor_ivld", a_ivld, 1);
        step();
        chk("t3_fault_pulse", a_fault, 0);

        // DEPTH=4 overflow: 20 bytes with load_valid held high.
        start_load();
        for (int i = 0; i < 20; i++) begin
            load_valid = 1'b1;
            load_data  = 8'(i + 1);
            step();
            if (i == 15) begin
                chk("t4_ready_drop", b_ready, 0);
                chk("t4_done", b_done, 1);
                chk("t4_ovf_not_yet", b_ovf, 0);
            end
            if (i == 16) chk("t4_ovf", b_ovf, 1);
        end
        load_valid = 1'b0;
        chk("t4_count", b_count, 4);
        chk("t4_busy", b_busy, 0);
        chk("t4_ovf_sticky", b_ovf, 1);
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i));
            chk("t4_word", b_instr, exp_b[i]);
        end
        fetch(4);
        chk("t4_oor_fault", b_fault, 1);
        chk("t4_oor_instr", b_instr, 32'h0);

        // Reset in the middle of a load.
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_ovf_clr", b_ovf, 0);
        start_load();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        chk("t5_busy_pre", a_busy, 1);
        rst = 1'b1;
        step();
        chk("t5_busy", a_busy, 0);
        chk("t5_ready", a_ready, 0);
        chk("t5_done", a_done, 0);
        load_start = 1'b1;
        step();
        chk("t5_rst_wins", a_busy, 0);
        rst = 1'b0; load_start = 1'b0;
        step();
        chk("t5_no_done", a_done, 0);
        fetch(0);
        chk("t5_no_fetch", a_ivld, 0);

        // Little-endian instance, then no consumption while in RUN.
        start_load();
        for (int i = 0; i < 4; i++) send_byte(img3[i], i == 3);
        chk("t6_done", c_done, 1);
        fetch(0);
        chk("t6_le_word", c_instr, 32'h12345678);
        chk("t6_be_word", a_instr, 32'h78563412);
        load_valid = 1'b1; load_data = 8'h99;
        step();
        chk("t6_ready", c_ready, 0);
        step();
        load_valid = 1'b0;
        chk("t6_count", c_count, 1);
        chk("t6_ovf", c_ovf, 0);
        fetch(1);
        chk("t6_unl", c_instr, 32'h0);
        chk("t6_unl_ivld", c_ivld, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
